// File: rtl/mj32_pkg.sv
// Shared definitions for the mj32 load path: load operation codes,
// load_unit FSM states and small decode helpers.
package mj32_pkg;

    // Load operation codes as presented on the operation input.
    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_LB   = 3'b001,
        OP_LH   = 3'b010,
        OP_LW   = 3'b011,
        OP_LBU  = 3'b100,
        OP_LHU  = 3'b101
    } load_op_e;

    // load_unit FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } load_state_e;

    // True for the five real load types; everything else is treated as NONE.
    function automatic logic op_is_load(input logic [2:0] op);
        logic r;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    // Halfwords need an even address, words a multiple of four; bytes never fault.
    function automatic logic op_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic r;
        case (op)
            OP_LH, OP_LHU: r = off[0];
            OP_LW:         r = (off != 2'b00);
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select and sign/zero extension of a little-endian
// read word according to the load type and the byte offset.
module load_extract (
    input  logic [2:0]  operation,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);
    import mj32_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte / halfword and extend it to 32 bits.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        result = 32'h0000_0000;

        case (offset)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase

        w_half = offset[1] ? word[31:16] : word[15:0];

        case (operation)
            OP_LB:   result = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  result = {24'h000000, w_byte};
            OP_LH:   result = {{16{w_half[15]}}, w_half};
            OP_LHU:  result = {16'h0000, w_half};
            OP_LW:   result = word;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load at a time, issues a word-aligned memory
// read, waits (bounded) for the acknowledge, and returns the extracted
// and extended data or an error pulse.
//
// Memory handshake: mem_req is held high with a stable mem_addr for every
// cycle spent in WAIT; the cycle in which mem_ack is high completes the
// transfer and mem_rdata is taken in that same cycle. mem_ack is ignored in
// any other state.
module load_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  operation,
    input  logic [31:0] address,
    input  logic [4:0]  rd_in,
    output logic        busy,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [4:0]  rd_out,
    output logic        load_err,
    output logic [1:0]  dbg_state
);
    import mj32_pkg::*;

    // The counter is compared against limit-1 so that the cycle in which
    // the count reaches the limit is the last WAIT cycle.
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    load_state_e r_state;
    load_state_e w_next_state;

    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [4:0]  r_rd;
    logic [31:0] r_mem_addr;
    logic [7:0]  r_cnt;
    logic [31:0] r_load_data;
    logic [4:0]  r_rd_out;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_cnt_last;
    logic [31:0] w_extracted;

    assign w_accept     = (r_state == ST_IDLE) && start && op_is_load(operation);
    assign w_misaligned = op_misaligned(operation, address[1:0]);
    assign w_cnt_last   = (r_cnt == LP_CNT_LAST);

    load_extract u_extract (
        .operation (r_op),
        .offset    (r_off),
        .word      (mem_rdata),
        .result    (w_extracted)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs; an ack on the last
    // counted WAIT cycle takes priority over the timeout.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        mem_req      = 1'b0;
        load_valid   = 1'b0;
        load_err     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_accept) begin
                    w_next_state = w_misaligned ? ST_ERR : ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next_state = ST_RESP;
                end else if (w_cnt_last) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_RESP: begin
                load_valid   = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                load_err     = 1'b1;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request capture, wait counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op        <= 3'b000;
            r_off       <= 2'b00;
            r_rd        <= 5'd0;
            r_mem_addr  <= 32'h0000_0000;
            r_cnt       <= 8'd0;
            r_load_data <= 32'h0000_0000;
            r_rd_out    <= 5'd0;
        end else begin
            if (w_accept && !w_misaligned) begin
                r_op       <= operation;
                r_off      <= address[1:0];
                r_rd       <= rd_in;
                r_mem_addr <= {address[31:2], 2'b00};
            end

            if (r_state == ST_WAIT) begin
                if (mem_ack) begin
                    r_load_data <= w_extracted;
                    r_rd_out    <= r_rd;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else begin
                r_cnt <= 8'd0;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign load_data = r_load_data;
    assign rd_out    = r_rd_out;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit with a short timeout so the timeout and the
// ack-on-last-cycle boundary are reachable quickly.
`timescale 1ns/1ps
module tb_load_unit;
    import mj32_pkg::*;

    localparam int TMO = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  operation;
    logic [31:0] address;
    logic [4:0]  rd_in;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        load_valid;
    logic [31:0] load_data;
    logic [4:0]  rd_out;
    logic        load_err;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .operation  (operation),
        .address    (address),
        .rd_in      (rd_in),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .load_valid (load_valid),
        .load_data  (load_data),
        .rd_out     (rd_out),
        .load_err   (load_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Response record: {load_valid, load_err, rd_out, load_data}
    logic [38:0] exp_q[$];
    logic [38:0] mon_e;
    logic        mon_en = 1'b0;
    logic [31:0] last_data = 32'h0;
    logic [4:0]  last_rd = 5'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          ack_wait;   // WAIT cycles before the ack; -1 = never
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_nreq;
        int          exp_lat;    // cycle of the response pulse; -1 = none
    } vec_t;

    vec_t vecs[$];
    vec_t rv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int ack_wait, input logic exp_err,
                           input logic [31:0] exp_data, input int exp_nreq, input int exp_lat);
        vec_t v;
        v.op = op; v.addr = addr; v.rd = rd; v.rdata = rdata; v.ack_wait = ack_wait;
        v.exp_err = exp_err; v.exp_data = exp_data; v.exp_nreq = exp_nreq; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // Reference extraction built from a byte array view of the word.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] off, input logic [31:0] w);
        logic [7:0]  b [4];
        logic [7:0]  sb;
        logic [15:0] h;
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        sb = b[off];
        h  = {b[{off[1], 1'b1}], b[{off[1], 1'b0}]};
        case (op)
            3'b001:  return {{24{sb[7]}}, sb};
            3'b100:  return {24'h0, sb};
            3'b010:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            3'b011:  return w;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en && (load_valid || load_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_response", {62'h0, load_valid, load_err}, 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("response", {25'h0, load_valid, load_err,
                                   load_err ? 5'd0 : rd_out, load_err ? 32'h0 : load_data},
                      {25'h0, mon_e});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_vec(input vec_t v, input int id);
        int   n_req;
        int   lat;
        logic done;
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        start = 1'b1; operation = v.op; address = v.addr; rd_in = v.rd;
        if (v.exp_lat >= 0) begin
            if (v.exp_err) exp_q.push_back({1'b0, 1'b1, 5'd0, 32'h0});
            else           exp_q.push_back({1'b1, 1'b0, v.rd, v.exp_data});
        end
        tick();
        start = 1'b0; operation = 3'($urandom_range(0, 7)); address = $urandom; rd_in = 5'($urandom);
        n_req = 0; lat = -1; done = 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            if (load_valid || load_err) lat = c;
            if (load_err) check($sformatf("v%0d_req_low_on_err", id), {63'h0, mem_req}, 64'h0);
            if (mem_req) begin
                n_req++;
                check($sformatf("v%0d_mem_addr", id), {32'h0, mem_addr}, {32'h0, exp_addr});
                if (v.ack_wait >= 0 && n_req == v.ack_wait + 1) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                end
            end
            if (!busy) done = 1'b1;
            else begin
                tick();
                mem_ack = 1'b0; mem_rdata = $urandom;
            end
        end
        if (!done) check($sformatf("v%0d_busy_bound", id), {63'h0, busy}, 64'h0);
        check($sformatf("v%0d_nreq", id), 64'(n_req), 64'(v.exp_nreq));
        check($sformatf("v%0d_latency", id), 64'(lat), 64'(v.exp_lat));
        if (v.exp_lat >= 0 && !v.exp_err) begin
            last_data = v.exp_data; last_rd = v.rd;
        end
        check($sformatf("v%0d_hold", id), {27'h0, rd_out, load_data}, {27'h0, last_rd, last_data});
    endtask

    // ---------------- test ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; operation = 3'b000; address = 32'h0;
        rd_in = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {58'h0, busy, mem_req, load_valid, load_err, dbg_state},
              {58'h0, 1'b0, 1'b0, 1'b0, 1'b0, ST_IDLE});
        check("rst_regs", {27'h0, rd_out, load_data}, 64'h0);
        check("rst_mem_addr", {32'h0, mem_addr}, 64'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;

        //       op      addr          rd     rdata          wait err data          nreq lat
        add_vec(OP_LB,  32'h0000_1003, 5'd1,  32'h80AA_BBCC,  0, 0, 32'hFFFF_FF80, 1, 2);
        add_vec(OP_LHU, 32'h0000_2002, 5'd2,  32'h8001_1234,  0, 0, 32'h0000_8001, 1, 2);
        add_vec(OP_LHU, 32'h0000_2002, 5'd3,  32'h8001_1234,  3, 0, 32'h0000_8001, 4, 5);
        add_vec(OP_LW,  32'h0000_0006, 5'd4,  32'h0,         -1, 1, 32'h0,         0, 1);
        add_vec(OP_LH,  32'h0000_0001, 5'd5,  32'h0,         -1, 1, 32'h0,         0, 1);
        add_vec(OP_LW,  32'h0000_0100, 5'd6,  32'h0,         -1, 1, 32'h0,         4, 5);
        add_vec(OP_LH,  32'h0000_3002, 5'd7,  32'hC0DE_5678,  1, 0, 32'hFFFF_C0DE, 2, 3);
        add_vec(OP_LH,  32'h0000_2000, 5'd8,  32'h0001_8765,  0, 0, 32'hFFFF_8765, 1, 2);
        add_vec(OP_LB,  32'h0000_4000, 5'd9,  32'h0000_007F,  0, 0, 32'h0000_007F, 1, 2);
        add_vec(OP_LBU, 32'h0000_4001, 5'd10, 32'h0000_F000,  2, 0, 32'h0000_00F0, 3, 4);
        add_vec(OP_LBU, 32'h0000_1002, 5'd11, 32'h80AA_BBCC,  0, 0, 32'h0000_00AA, 1, 2);
        add_vec(OP_LW,  32'h0000_5004, 5'd12, 32'hDEAD_BEEF,  2, 0, 32'hDEAD_BEEF, 3, 4);
        add_vec(3'b000, 32'h0000_0010, 5'd13, 32'h0,         -1, 0, 32'h0,         0, -1);
        add_vec(3'b110, 32'h0000_0010, 5'd14, 32'h0,         -1, 0, 32'h0,         0, -1);
        add_vec(3'b111, 32'h0000_0020, 5'd15, 32'h0,         -1, 0, 32'h0,         0, -1);
        add_vec(OP_LHU, 32'h0000_0003, 5'd16, 32'h0,         -1, 1, 32'h0,         0, 1);
        add_vec(OP_LBU, 32'hFFFF_FFFF, 5'd31, 32'h7F00_0000,  3, 0, 32'h0000_007F, 4, 5);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // start while busy is dropped, not queued
        start = 1'b1; operation = OP_LW; address = 32'h20; rd_in = 5'd3;
        exp_q.push_back({1'b1, 1'b0, 5'd3, 32'h1122_3344});
        tick();
        operation = OP_LB; address = 32'h31; rd_in = 5'd9;
        tick();
        check("busy_start_addr", {32'h0, mem_addr}, {32'h0, 32'h20});
        start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
        tick();
        mem_ack = 1'b0;
        tick();
        check("busy_start_done", {27'h0, rd_out, load_data}, {27'h0, 5'd3, 32'h1122_3344});
        last_data = 32'h1122_3344; last_rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("busy_start_no_queue", {62'h0, busy, mem_req}, 64'h0);
        end

        // NONE start together with a stray ack in IDLE
        start = 1'b1; operation = OP_NONE; address = 32'h44; mem_ack = 1'b1;
        tick();
        start = 1'b0;
        check("none_stray_ack", {62'h0, busy, mem_req}, 64'h0);
        tick();
        mem_ack = 1'b0;
        check("none_stray_ack_hold", {27'h0, rd_out, load_data}, {27'h0, last_rd, last_data});

        // reset during WAIT, then a late ack
        start = 1'b1; operation = OP_LW; address = 32'h40; rd_in = 5'd7;
        tick();
        start = 1'b0;
        check("rstwait_in_wait", {62'h0, dbg_state}, {62'h0, ST_WAIT});
        rst_n = 1'b0;
        tick();
        check("rstwait_req_low", {62'h0, busy, mem_req}, 64'h0);
        check("rstwait_regs", {27'h0, rd_out, load_data}, 64'h0);
        check("rstwait_mem_addr", {32'h0, mem_addr}, 64'h0);
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack = 1'b0;
        last_data = 32'h0; last_rd = 5'd0;
        repeat (3) tick();
        check("rstwait_idle", {60'h0, busy, mem_req, dbg_state}, {60'h0, 1'b0, 1'b0, ST_IDLE});

        // random aligned loads, expected data from the model
        for (int i = 0; i < 16; i++) begin
            rv.op = 3'($urandom_range(1, 5));
            rv.addr = $urandom;
            if (rv.op == OP_LW) rv.addr[1:0] = 2'b00;
            if (rv.op == OP_LH || rv.op == OP_LHU) rv.addr[0] = 1'b0;
            rv.rd = 5'($urandom);
            rv.rdata = $urandom;
            rv.ack_wait = $urandom_range(0, TMO - 1);
            rv.exp_err = 1'b0;
            rv.exp_data = model(rv.op, rv.addr[1:0], rv.rdata);
            rv.exp_nreq = rv.ack_wait + 1;
            rv.exp_lat = rv.ack_wait + 2;
            run_vec(rv, 100 + i);
        end

        repeat (2) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
